// File: rtl/reg_bank_sel.sv
// rtl/reg_bank_sel.sv - register bank with two registered read ports and a sequenced clear; define REG_BANK_SEL_BYPASS_EN for write-to-read forwarding
module reg_bank_sel #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  localparam int SELW = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [SELW-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [SELW-1:0]  rsel_a,
  input  logic [SELW-1:0]  rsel_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid,
  input  logic             clr_req,
  output logic             busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SELW-1:0]  cidx_q, cidx_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic             rvalid_q, rvalid_d;

  // FSM state and clear index register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cidx_q  <= '0;
    end else begin
      state_q <= state_d;
      cidx_q  <= cidx_d;
    end
  end

  // Next state plus bank update: writes only land in IDLE, CLEAR zeroes one entry per cycle
  always_comb begin
    state_d = state_q;
    cidx_d  = cidx_q;
    regs_d  = regs_q;
    case (state_q)
      S_IDLE: begin
        if (we) begin
          regs_d[waddr] = wdata;
        end
        // A simultaneous write still lands first; the sweep then zeroes it too
        if (clr_req) begin
          state_d = S_CLEAR;
          cidx_d  = '0;
        end
      end
      S_CLEAR: begin
        regs_d[cidx_q] = '0;
        cidx_d         = cidx_q + 1'b1;
        if (cidx_q == SELW'(NREG - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read capture: both ports sample on re, otherwise hold; rvalid marks a fresh capture
  always_comb begin
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    rvalid_d  = re;
    if (re) begin
      rdata_a_d = regs_q[rsel_a];
      rdata_b_d = regs_q[rsel_b];
`ifdef REG_BANK_SEL_BYPASS_EN
      // Forward the write only when it is actually accepted (IDLE)
      if ((state_q == S_IDLE) && we && (waddr == rsel_a)) begin
        rdata_a_d = wdata;
      end
      if ((state_q == S_IDLE) && we && (waddr == rsel_b)) begin
        rdata_b_d = wdata;
      end
`endif
    end
  end

  // Register bank and read port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q    <= '{default: '0};
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign rvalid  = rvalid_q;
  assign busy    = (state_q == S_CLEAR);

endmodule
